// File: rtl/hc595_sequencer_pkg.sv
// Shared types and constants for the 74HC595 serializer sequencer.
package hc595_sequencer_pkg;

    // Sequencer FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Requester indices
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Round-robin pick: on contention the requester not granted last wins
    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        logic win;
        if (r0 && r1) begin
            win = ~last;
        end else if (r1) begin
            win = REQ1;
        end else begin
            win = REQ0;
        end
        return win;
    endfunction

endpackage

// File: rtl/hc595_sequencer_shift_register.sv
// Parallel-load, MSB-first serializer; shifts left with zero fill whenever load is low.
module hc595_sequencer_shift_register #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  serial_out
);

    logic [DATA_WIDTH-1:0] sr_q;

    // Load the word or shift it out one bit per clock
    always_ff @(posedge clk) begin
        if (load) begin
            sr_q <= data;
        end else begin
            sr_q <= sr_q << 1;
        end
    end

    assign serial_out = sr_q[DATA_WIDTH-1];

endmodule

// File: rtl/hc595_sequencer.sv
// Round-robin arbitrated sequencer feeding one MSB-first serializer with valid strobe and RCLK latch pulse.
module hc595_sequencer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack1,
    output logic                  ser_data,
    output logic                  ser_valid,
    output logic                  latch,
    output logic                  busy
);

    import hc595_sequencer_pkg::*;

    localparam int unsigned       CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                  state, state_next;
    logic                    last_grant, last_grant_next;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_next;
    logic                    sr_load, sr_load_next;
    logic [DATA_WIDTH-1:0]   sr_data, sr_data_next;
    logic                    ack0_next, ack1_next;
    logic                    ser_valid_next, latch_next, busy_next;
    logic                    win;
    logic                    sr_msb;

    // Next-state, arbitration and registered-output decode
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        bit_cnt_next    = bit_cnt;
        sr_load_next    = 1'b0;
        sr_data_next    = sr_data;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        ser_valid_next  = 1'b0;
        latch_next      = 1'b0;
        win             = rr_pick(req0, req1, last_grant);

        case (state)
            IDLE, LATCH: begin
                if (req0 || req1) begin
                    state_next      = LOAD;
                    sr_load_next    = 1'b1;
                    sr_data_next    = (win == REQ1) ? data1 : data0;
                    ack0_next       = (win == REQ0);
                    ack1_next       = (win == REQ1);
                    last_grant_next = win;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                state_next     = SHIFT;
                ser_valid_next = 1'b1;
                bit_cnt_next   = '0;
            end
            SHIFT: begin
                if (bit_cnt == CNT_LAST) begin
                    state_next = LATCH;
                    latch_next = 1'b1;
                end else begin
                    ser_valid_next = 1'b1;
                    bit_cnt_next   = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset flushes the serializer with zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ1;
            bit_cnt    <= '0;
            sr_load    <= 1'b1;
            sr_data    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ser_valid  <= 1'b0;
            latch      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            bit_cnt    <= bit_cnt_next;
            sr_load    <= sr_load_next;
            sr_data    <= sr_data_next;
            ack0       <= ack0_next;
            ack1       <= ack1_next;
            ser_valid  <= ser_valid_next;
            latch      <= latch_next;
            busy       <= busy_next;
        end
    end

    hc595_sequencer_shift_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_register (
        .clk        (clk),
        .load       (sr_load),
        .data       (sr_data),
        .serial_out (sr_msb)
    );

    // Serializer MSB qualified by the strobe so the line idles low, including during reset
    assign ser_data = ser_valid & sr_msb;

endmodule

// File: tb/tb_hc595_sequencer.sv
// Self-checking bench for hc595_sequencer: queue-driven requesters, transaction-level model, per-cycle monitor.
module tb_hc595_sequencer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [DW-1:0] data0, data1;
    logic          ack0, ack1, ser_data, ser_valid, latch, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // requester word queues and the manual override for requester 0
    logic [DW-1:0] words0[$];
    logic [DW-1:0] words1[$];
    logic          man0 = 1'b0;
    logic          model_last = 1'b1;

    // model expectations
    int            exp_who[$];
    logic [DW-1:0] exp_word[$];

    // monitor observations
    int          ack_cyc[$];
    int          ack_who[$];
    logic [31:0] burst_word[$];
    int          burst_len[$];
    int          burst_start[$];
    int          latch_cyc[$];
    int          busy_rise[$];
    int          busy_fall[$];
    int          req_rise0[$];
    int          both_err  = 0;
    int          stray_err = 0;
    logic [31:0] cur_word  = 0;
    int          cur_len   = 0;
    int          cur_start = 0;
    logic        prev_busy = 1'b0;
    logic        prev_req0 = 1'b0;

    hc595_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .data1     (data1),
        .ack1      (ack1),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .latch     (latch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold request while a word is queued, random data otherwise
    always @(posedge clk) begin
        #1;
        if (!man0) begin
            req0  = (words0.size() != 0);
            data0 = (words0.size() != 0) ? words0[0] : DW'($urandom);
        end
        req1  = (words1.size() != 0);
        data1 = (words1.size() != 0) ? words1[0] : DW'($urandom);
    end

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        if (ack0) begin
            ack_cyc.push_back(cyc);
            ack_who.push_back(0);
            if (words0.size() != 0) void'(words0.pop_front());
        end
        if (ack1) begin
            ack_cyc.push_back(cyc);
            ack_who.push_back(1);
            if (words1.size() != 0) void'(words1.pop_front());
        end
        if (ack0 && ack1) both_err++;
        if (ser_data && !ser_valid) stray_err++;
        if (ser_valid) begin
            if (cur_len == 0) cur_start = cyc;
            cur_word = (cur_word << 1) | 32'(ser_data);
            cur_len++;
        end else if (cur_len != 0) begin
            burst_word.push_back(cur_word);
            burst_len.push_back(cur_len);
            burst_start.push_back(cur_start);
            cur_len  = 0;
            cur_word = 0;
        end
        if (latch) latch_cyc.push_back(cyc);
        if (busy && !prev_busy) busy_rise.push_back(cyc);
        if (!busy && prev_busy) busy_fall.push_back(cyc);
        if (req0 && !prev_req0) req_rise0.push_back(cyc);
        prev_busy = busy;
        prev_req0 = req0;
    end

    task automatic clear_mon();
        ack_cyc.delete(); ack_who.delete();
        burst_word.delete(); burst_len.delete(); burst_start.delete();
        latch_cyc.delete(); busy_rise.delete(); busy_fall.delete(); req_rise0.delete();
        both_err = 0; stray_err = 0; cur_len = 0; cur_word = 0;
    endtask

    // Transaction-level round-robin model over the queued words
    task automatic predict();
        logic [DW-1:0] q0[$];
        logic [DW-1:0] q1[$];
        logic last;
        int w;
        q0 = words0; q1 = words1; last = model_last;
        exp_who.delete(); exp_word.delete();
        while (q0.size() != 0 || q1.size() != 0) begin
            if (q0.size() != 0 && q1.size() != 0) w = last ? 0 : 1;
            else if (q1.size() != 0) w = 1;
            else w = 0;
            exp_who.push_back(w);
            if (w == 0) exp_word.push_back(q0.pop_front());
            else exp_word.push_back(q1.pop_front());
            last = (w == 1);
        end
        model_last = last;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Run until all queued words are served and the block sits idle
    task automatic run_until_quiet(input int max_cycles);
        int  quiet;
        logic done;
        quiet = 0; done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (words0.size() == 0 && words1.size() == 0 && !busy && !req0 && !req1) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin done = 1'b1; break; end
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL quiet_timeout: still busy after %0d cycles, required idle", max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack0, ack1, ser_data, ser_valid, latch, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_held: outputs=%b required=000000", {ack0, ack1, ser_data, ser_valid, latch, busy});
        end
        rst = 1'b0;
        model_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack0, ack1, ser_data, ser_valid, latch, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_idle: outputs=%b required=000000", {ack0, ack1, ser_data, ser_valid, latch, busy});
        end
    endtask

    task automatic test_single();
        clear_mon();
        words0.push_back(8'hA5);
        predict();
        run_until_quiet(60);
        checks++;
        if (ack_who.size() != 1 || ack_who[0] != 0) begin
            failures++;
            $display("FAIL single_ack: acks=%0d who=%0d required 1 ack from requester 0", ack_who.size(), ack_who[0]);
        end
        checks++;
        if (req_rise0.size() != 1 || ack_cyc[0] - req_rise0[0] != 1) begin
            failures++;
            $display("FAIL single_latency: got %0d cycles required 1", ack_cyc[0] - req_rise0[0]);
        end
        checks++;
        if (burst_word.size() != 1 || burst_word[0] !== 32'(exp_word[0]) || burst_len[0] != DW) begin
            failures++;
            $display("FAIL single_bits: word=%h len=%0d required word=%h len=%0d", burst_word[0], burst_len[0], exp_word[0], DW);
        end
        checks++;
        if (burst_start[0] != ack_cyc[0] + 1) begin
            failures++;
            $display("FAIL single_first_bit: cycle %0d required %0d", burst_start[0], ack_cyc[0] + 1);
        end
        checks++;
        if (latch_cyc.size() != 1 || latch_cyc[0] != burst_start[0] + DW) begin
            failures++;
            $display("FAIL single_latch: pulses=%0d at %0d required 1 at %0d", latch_cyc.size(), latch_cyc[0], burst_start[0] + DW);
        end
        checks++;
        if (busy_rise.size() != 1 || busy_fall.size() != 1 || busy_rise[0] != ack_cyc[0] || busy_fall[0] != latch_cyc[0] + 1) begin
            failures++;
            $display("FAIL single_busy: rise=%0d fall=%0d required rise=%0d fall=%0d", busy_rise[0], busy_fall[0], ack_cyc[0], latch_cyc[0] + 1);
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        clear_mon();
        words0.push_back(8'h0F);
        words1.push_back(8'hF0);
        predict();
        run_until_quiet(80);
        checks++;
        if (ack_who.size() != 2 || burst_word.size() != 2) begin
            failures++;
            $display("FAIL same_count: acks=%0d bursts=%0d required 2", ack_who.size(), burst_word.size());
        end
        for (int i = 0; i < exp_who.size(); i++) begin
            checks++;
            if (ack_who[i] != exp_who[i] || burst_word[i] !== 32'(exp_word[i])) begin
                failures++;
                $display("FAIL same_order[%0d]: who=%0d word=%h required who=%0d word=%h", i, ack_who[i], burst_word[i], exp_who[i], exp_word[i]);
            end
        end
        checks++;
        if (ack_cyc[1] - ack_cyc[0] != DW + 2) begin
            failures++;
            $display("FAIL same_ack_gap: %0d cycles required %0d", ack_cyc[1] - ack_cyc[0], DW + 2);
        end
        checks++;
        if (burst_start[1] - (burst_start[0] + DW) != 2) begin
            failures++;
            $display("FAIL same_valid_gap: %0d cycles required 2", burst_start[1] - (burst_start[0] + DW));
        end
    endtask

    task automatic test_alternate();
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            words0.push_back(DW'($urandom));
            words1.push_back(DW'($urandom));
        end
        predict();
        run_until_quiet(200);
        checks++;
        if (ack_who.size() != 6 || burst_word.size() != 6) begin
            failures++;
            $display("FAIL alt_count: acks=%0d bursts=%0d required 6", ack_who.size(), burst_word.size());
        end
        for (int i = 0; i < exp_who.size(); i++) begin
            checks++;
            if (ack_who[i] != exp_who[i] || burst_word[i] !== 32'(exp_word[i]) || burst_len[i] != DW) begin
                failures++;
                $display("FAIL alt_order[%0d]: who=%0d word=%h len=%0d required who=%0d word=%h len=%0d", i, ack_who[i], burst_word[i], burst_len[i], exp_who[i], exp_word[i], DW);
            end
        end
        for (int i = 1; i < ack_cyc.size(); i++) begin
            checks++;
            if (ack_cyc[i] - ack_cyc[i-1] != DW + 2) begin
                failures++;
                $display("FAIL alt_period[%0d]: %0d cycles required %0d", i, ack_cyc[i] - ack_cyc[i-1], DW + 2);
            end
        end
        checks++;
        if (both_err != 0) begin
            failures++;
            $display("FAIL alt_both_ack: %0d cycles with both acks required 0", both_err);
        end
    endtask

    task automatic test_req1_only();
        clear_mon();
        for (int i = 0; i < 3; i++) words1.push_back(8'hFF);
        words1.push_back(DW'($urandom));
        predict();
        run_until_quiet(200);
        checks++;
        if (ack_who.size() != 4 || latch_cyc.size() != 4) begin
            failures++;
            $display("FAIL r1_count: acks=%0d latches=%0d required 4", ack_who.size(), latch_cyc.size());
        end
        for (int i = 0; i < exp_who.size(); i++) begin
            checks++;
            if (ack_who[i] != exp_who[i] || burst_word[i] !== 32'(exp_word[i])) begin
                failures++;
                $display("FAIL r1_word[%0d]: who=%0d word=%h required who=%0d word=%h", i, ack_who[i], burst_word[i], exp_who[i], exp_word[i]);
            end
        end
        for (int i = 1; i < ack_cyc.size(); i++) begin
            checks++;
            if (ack_cyc[i] - ack_cyc[i-1] != DW + 2) begin
                failures++;
                $display("FAIL r1_period[%0d]: %0d cycles required %0d", i, ack_cyc[i] - ack_cyc[i-1], DW + 2);
            end
        end
        checks++;
        if (stray_err != 0) begin
            failures++;
            $display("FAIL r1_stray_data: %0d cycles ser_data without ser_valid required 0", stray_err);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        clear_mon();
        words0.push_back(8'hC3);
        void'(predict_dummy());
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (cur_len == 3) begin seen = 1'b1; break; end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL mid_third_bit: third bit not seen, required within 40 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_valid, latch, ser_data, busy, ack0, ack1} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_now: outputs=%b required=000000", {ser_valid, latch, ser_data, busy, ack0, ack1});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1'b1;
        checks++;
        if (latch_cyc.size() != 0) begin
            failures++;
            $display("FAIL mid_no_latch: %0d latch pulses required 0", latch_cyc.size());
        end
        clear_mon();
        words0.push_back(8'h81);
        predict();
        run_until_quiet(60);
        checks++;
        if (burst_word.size() != 1 || burst_word[0] !== 32'(exp_word[0]) || burst_len[0] != DW || latch_cyc.size() != 1) begin
            failures++;
            $display("FAIL mid_after: bursts=%0d word=%h len=%0d latches=%0d required 1 word=%h len=%0d latches=1", burst_word.size(), burst_word[0], burst_len[0], latch_cyc.size(), exp_word[0], DW);
        end
    endtask

    // The aborted word is never completed, so the model has nothing to predict for it
    function automatic int predict_dummy();
        return 0;
    endfunction

    task automatic test_pulse_ignored();
        logic seen;
        clear_mon();
        words1.push_back(DW'($urandom));
        predict();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (cur_len >= 2) begin seen = 1'b1; break; end
        end
        man0  = 1'b1;
        req0  = 1'b1;
        data0 = DW'($urandom);
        @(posedge clk); #1;
        req0 = 1'b0;
        man0 = 1'b0;
        run_until_quiet(60);
        checks++;
        if (seen !== 1'b1 || ack_who.size() != 1 || ack_who[0] != 1) begin
            failures++;
            $display("FAIL pulse_acks: acks=%0d first_who=%0d required only requester 1", ack_who.size(), ack_who[0]);
        end
        checks++;
        if (burst_word.size() != 1 || burst_word[0] !== 32'(exp_word[0])) begin
            failures++;
            $display("FAIL pulse_word: bursts=%0d word=%h required 1 word=%h", burst_word.size(), burst_word[0], exp_word[0]);
        end
        checks++;
        if (latch_cyc.size() != 1 || busy_fall.size() != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pulse_idle: latches=%0d busy_falls=%0d busy=%b required 1 1 0", latch_cyc.size(), busy_fall.size(), busy);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = '0;
        data1 = '0;
        test_reset();
        test_single();
        test_same_cycle();
        test_alternate();
        test_req1_only();
        test_reset_mid();
        test_pulse_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
